// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA timing generator driven from the 50 MHz
// board clock. A 1-bit divider makes the 25 MHz pixel enable. The pixel
// counters free-run from reset. hsync/vsync are registered from the
// next-count values, so they line up with pixel_x/pixel_y with no skew.
module vga_sync_gen #(
    parameter int   H_DISPLAY   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_DISPLAY   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       CLK_50MHZ,
    input  logic       RESET,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick
);

    // Each axis total must fit in the 10-bit counters (total <= 1024).
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic       divider;
    logic [9:0] h_count;
    logic [9:0] v_count;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_end;
    logic       v_end;
    logic       hsync_next;
    logic       vsync_next;

    // Next-count computation: counters only move on a pixel-enable cycle.
    always_comb begin
        h_end  = (h_count == H_MAX);
        v_end  = (v_count == V_MAX);
        h_next = h_count;
        v_next = v_count;
        if (divider) begin
            if (h_end) begin
                h_next = 10'd0;
                if (v_end) begin
                    v_next = 10'd0;
                end else begin
                    v_next = v_count + 10'd1;
                end
            end else begin
                h_next = h_count + 10'd1;
            end
        end
        hsync_next = ((h_next >= HS_START) && (h_next <= HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_next = ((v_next >= VS_START) && (v_next <= VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    // Divider, pixel counters and syncs; reset restarts timing at pixel (0,0).
    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            divider <= 1'b0;
            h_count <= 10'd0;
            v_count <= 10'd0;
            hsync   <= ~SYNC_ACTIVE;
            vsync   <= ~SYNC_ACTIVE;
        end else begin
            divider <= ~divider;
            h_count <= h_next;
            v_count <= v_next;
            hsync   <= hsync_next;
            vsync   <= vsync_next;
        end
    end

    assign p_tick     = divider;
    assign pixel_x    = h_count;
    assign pixel_y    = v_count;
    assign video_on   = (h_count < H_VIS) && (v_count < V_VIS);
    assign line_tick  = divider && h_end;
    assign frame_tick = line_tick && v_end;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen. One instance uses the real 640x480 timing for
// reset and line-level checks. A second instance uses a shrunken timing so
// that full frames, the visible-area corners, mid-frame reset and the refresh
// condition fit in a short run. Expected outputs come from a reference model
// indexed by the number of cycles since reset, queued and compared each cycle.
module tb_vga_sync_gen;

    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
        logic       line_tick;
        logic       frame_tick;
    } obs_t;

    // Shrunken timing for the frame-level instance.
    localparam int SH_D = 16, SH_F = 2, SH_S = 4, SH_B = 3;
    localparam int SV_D = 8,  SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int ST_H = SH_D + SH_F + SH_S + SH_B;   // 25
    localparam int ST_V = SV_D + SV_F + SV_S + SV_B;   // 15
    localparam int S_FR = 2 * ST_H * ST_V;             // CLK cycles per frame

    logic clk;
    logic f_rst, s_rst;

    logic       f_ptick, f_von, f_hs, f_vs, f_lt, f_ft;
    logic [9:0] f_x, f_y;
    logic       s_ptick, s_von, s_hs, s_vs, s_lt, s_ft;
    logic [9:0] s_x, s_y;
    obs_t       f_obs, s_obs;

    int checks = 0;
    int errors = 0;
    int f_n = 0;
    int s_n = 0;
    obs_t sb_q[$];

    vga_sync_gen u_full (
        .CLK_50MHZ (clk),
        .RESET     (f_rst),
        .p_tick    (f_ptick),
        .pixel_x   (f_x),
        .pixel_y   (f_y),
        .video_on  (f_von),
        .hsync     (f_hs),
        .vsync     (f_vs),
        .line_tick (f_lt),
        .frame_tick(f_ft)
    );

    vga_sync_gen #(
        .H_DISPLAY(SH_D), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_DISPLAY(SV_D), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
        .SYNC_ACTIVE(1'b0)
    ) u_small (
        .CLK_50MHZ (clk),
        .RESET     (s_rst),
        .p_tick    (s_ptick),
        .pixel_x   (s_x),
        .pixel_y   (s_y),
        .video_on  (s_von),
        .hsync     (s_hs),
        .vsync     (s_vs),
        .line_tick (s_lt),
        .frame_tick(s_ft)
    );

    assign f_obs = {f_ptick, f_x, f_y, f_von, f_hs, f_vs, f_lt, f_ft};
    assign s_obs = {s_ptick, s_x, s_y, s_von, s_hs, s_vs, s_lt, s_ft};

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected outputs n cycles after reset release (n = 0 is the first
    // sample after the reset edge). Pixel k is held for cycles 2k and 2k+1.
    function automatic obs_t model(input int n, input int hd, input int hf,
                                   input int hs, input int hb, input int vd,
                                   input int vf, input int vs, input int vb);
        obs_t m;
        int ht, vt, k, x, y;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        k  = n / 2;
        x  = k % ht;
        y  = (k / ht) % vt;
        m.p_tick     = (n % 2) == 1;
        m.x          = 10'(x);
        m.y          = 10'(y);
        m.video_on   = (x < hd) && (y < vd);
        m.hsync      = !((x >= hd + hf) && (x < hd + hf + hs));
        m.vsync      = !((y >= vd + vf) && (y < vd + vf + vs));
        m.line_tick  = m.p_tick && (x == ht - 1);
        m.frame_tick = m.line_tick && (y == vt - 1);
        return m;
    endfunction

    task automatic test_reset();
        f_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (f_x !== 10'd0 || f_ptick !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: x=%0d p_tick=%b, required x=0 p_tick=0", f_x, f_ptick);
        end
        f_rst = 1'b0;
        f_n = 0;
        checks++;
        if (f_x !== 10'd0 || f_y !== 10'd0 || f_hs !== 1'b1 || f_vs !== 1'b1 ||
            f_von !== 1'b1 || f_ptick !== 1'b0 || f_lt !== 1'b0 || f_ft !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle0: x=%0d y=%0d hs=%b vs=%b von=%b pt=%b lt=%b ft=%b, required 0 0 1 1 1 0 0 0",
                     f_x, f_y, f_hs, f_vs, f_von, f_ptick, f_lt, f_ft);
        end
        @(negedge clk);
        f_n = 1;
        checks++;
        if (f_ptick !== 1'b1 || f_x !== 10'd0) begin
            errors++;
            $display("FAIL reset_cycle1: p_tick=%b x=%0d, required p_tick=1 x=0", f_ptick, f_x);
        end
        @(negedge clk);
        f_n = 2;
        checks++;
        if (f_x !== 10'd1 || f_ptick !== 1'b0) begin
            errors++;
            $display("FAIL reset_cycle2: x=%0d p_tick=%b, required x=1 p_tick=0", f_x, f_ptick);
        end
    endtask

    task automatic test_line();
        obs_t exp;
        int hs_low = 0;
        int lt_cyc = 0;
        int wraps  = 0;
        int vis_hits = 0;
        logic [9:0] prev_x;
        prev_x = f_x;
        while (f_n < 1700) begin
            @(negedge clk);
            f_n++;
            sb_q.push_back(model(f_n, 640, 16, 96, 48, 480, 10, 2, 33));
            exp = sb_q.pop_front();
            checks++;
            if (f_obs !== exp) begin
                errors++;
                $display("FAIL line_sb n=%0d: got %h (x=%0d y=%0d), required %h (x=%0d y=%0d)",
                         f_n, f_obs, f_x, f_y, exp, exp.x, exp.y);
            end
            if (f_hs === 1'b0) hs_low++;
            if (f_lt === 1'b1) lt_cyc++;
            if (f_x == 10'd639 || f_x == 10'd640) begin
                vis_hits++;
                checks++;
                if (f_von !== (f_x == 10'd639)) begin
                    errors++;
                    $display("FAIL line_visible x=%0d: video_on=%b, required %b", f_x, f_von, f_x == 10'd639);
                end
            end
            if (prev_x == 10'd799 && f_x != 10'd799) begin
                wraps++;
                checks++;
                if (f_x !== 10'd0 || f_y !== 10'd1) begin
                    errors++;
                    $display("FAIL line_wrap: x=%0d y=%0d, required x=0 y=1", f_x, f_y);
                end
            end
            prev_x = f_x;
        end
        checks++;
        if (hs_low != 192) begin
            errors++;
            $display("FAIL line_hsync_width: %0d cycles low, required 192", hs_low);
        end
        checks++;
        if (lt_cyc != 1) begin
            errors++;
            $display("FAIL line_tick_count: %0d cycles high, required 1", lt_cyc);
        end
        checks++;
        if (wraps != 1 || vis_hits != 4) begin
            errors++;
            $display("FAIL line_coverage: wraps=%0d visible_hits=%0d, required 1 and 4", wraps, vis_hits);
        end
    endtask

    task automatic test_frame();
        obs_t exp;
        int vs_low = 0;
        int ft_cnt = 0;
        int last_ft = -1;
        int y_wraps = 0;
        int run_len = 0;
        int runs = 0;
        int corner_hits = 0;
        logic [9:0] prev_y;
        logic exp_von;
        s_rst = 1'b1;
        repeat (2) @(negedge clk);
        s_rst = 1'b0;
        s_n = 0;
        prev_y = s_y;
        while (s_n < 3 * S_FR) begin
            sb_q.push_back(model(s_n, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B));
            exp = sb_q.pop_front();
            checks++;
            if (s_obs !== exp) begin
                errors++;
                $display("FAIL frame_sb n=%0d: got %h (x=%0d y=%0d), required %h (x=%0d y=%0d)",
                         s_n, s_obs, s_x, s_y, exp, exp.x, exp.y);
            end
            if (s_n < S_FR && s_vs === 1'b0) vs_low++;
            if (s_ft === 1'b1) begin
                ft_cnt++;
                if (last_ft >= 0) begin
                    checks++;
                    if (s_n - last_ft != S_FR) begin
                        errors++;
                        $display("FAIL frame_tick_period: %0d cycles, required %0d", s_n - last_ft, S_FR);
                    end
                end
                last_ft = s_n;
            end
            if (prev_y == 10'(ST_V - 1) && s_y != 10'(ST_V - 1)) begin
                y_wraps++;
                checks++;
                if (s_y !== 10'd0) begin
                    errors++;
                    $display("FAIL frame_y_wrap: y=%0d, required 0", s_y);
                end
            end
            prev_y = s_y;
            if ((s_x == 10'(SH_D - 1) && s_y == 10'(SV_D - 1)) ||
                (s_x == 10'(SH_D)     && s_y == 10'(SV_D - 1)) ||
                (s_x == 10'd0         && s_y == 10'(SV_D))     ||
                (s_x == 10'(ST_H - 1) && s_y == 10'(ST_V - 1))) begin
                corner_hits++;
                exp_von = (s_x == 10'(SH_D - 1));
                checks++;
                if (s_von !== exp_von) begin
                    errors++;
                    $display("FAIL frame_visible (%0d,%0d): video_on=%b, required %b", s_x, s_y, s_von, exp_von);
                end
            end
            if (s_y == 10'(SV_D + 1) && s_x == 10'd0) begin
                run_len++;
            end else if (run_len > 0) begin
                runs++;
                checks++;
                if (run_len != 2) begin
                    errors++;
                    $display("FAIL refresh_run_length: %0d cycles, required 2", run_len);
                end
                run_len = 0;
            end
            @(negedge clk);
            s_n++;
        end
        checks++;
        if (vs_low != SV_S * ST_H * 2) begin
            errors++;
            $display("FAIL frame_vsync_width: %0d cycles low, required %0d", vs_low, SV_S * ST_H * 2);
        end
        checks++;
        if (ft_cnt != 3) begin
            errors++;
            $display("FAIL frame_tick_count: %0d, required 3", ft_cnt);
        end
        checks++;
        if (y_wraps != 2) begin
            errors++;
            $display("FAIL frame_y_wrap_count: %0d, required 2", y_wraps);
        end
        checks++;
        if (runs != 3) begin
            errors++;
            $display("FAIL refresh_runs: %0d per 3 frames, required 3", runs);
        end
        checks++;
        if (corner_hits != 24) begin
            errors++;
            $display("FAIL frame_corner_hits: %0d, required 24", corner_hits);
        end
    endtask

    task automatic test_mid_reset();
        obs_t exp;
        int guard = 0;
        while (!(s_x == 10'd20 && s_y == 10'd6) && guard < S_FR + 4) begin
            @(negedge clk);
            s_n++;
            guard++;
        end
        checks++;
        if (!(s_x == 10'd20 && s_y == 10'd6) || s_hs !== 1'b0) begin
            errors++;
            $display("FAIL midreset_reach: x=%0d y=%0d hs=%b, required x=20 y=6 hs=0", s_x, s_y, s_hs);
        end
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        s_n = 0;
        checks++;
        if (s_x !== 10'd0 || s_y !== 10'd0 || s_hs !== 1'b1 || s_vs !== 1'b1 ||
            s_ptick !== 1'b0 || s_von !== 1'b1) begin
            errors++;
            $display("FAIL midreset_cycle0: x=%0d y=%0d hs=%b vs=%b pt=%b von=%b, required 0 0 1 1 0 1",
                     s_x, s_y, s_hs, s_vs, s_ptick, s_von);
        end
        while (s_n < S_FR + 10) begin
            @(negedge clk);
            s_n++;
            sb_q.push_back(model(s_n, SH_D, SH_F, SH_S, SH_B, SV_D, SV_F, SV_S, SV_B));
            exp = sb_q.pop_front();
            checks++;
            if (s_obs !== exp) begin
                errors++;
                $display("FAIL midreset_sb n=%0d: got %h (x=%0d y=%0d), required %h (x=%0d y=%0d)",
                         s_n, s_obs, s_x, s_y, exp, exp.x, exp.y);
            end
        end
    endtask

    initial begin
        f_rst = 1'b1;
        s_rst = 1'b1;
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
